// File: rtl/lvds_pkg.sv
// Shared LVDS panel definitions: active-area timing, pattern modes and colours.
// Imported by the pattern generator and the LVDS transmitter.
package lvds_pkg;

    localparam int unsigned HACTIVE   = 960;
    localparam int unsigned VACTIVE   = 1200;
    localparam int unsigned BAR_WIDTH = HACTIVE / 8;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_GRAD  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BOX   = 2'd3
    } mode_e;

    localparam logic [23:0] COLOR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COLOR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COLOR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COLOR_GREEN   = 24'h00FF00;
    localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COLOR_RED     = 24'hFF0000;
    localparam logic [23:0] COLOR_BLUE    = 24'h0000FF;
    localparam logic [23:0] COLOR_BLACK   = 24'h000000;

    localparam logic [7:0]  GRAD_BLUE     = 8'h80;
    localparam logic [23:0] BOX_FG        = 24'h00FF00;
    localparam logic [23:0] BOX_BG        = 24'h000040;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        c = COLOR_BLACK;
        unique case (idx)
            3'd0: c = COLOR_WHITE;
            3'd1: c = COLOR_YELLOW;
            3'd2: c = COLOR_CYAN;
            3'd3: c = COLOR_GREEN;
            3'd4: c = COLOR_MAGENTA;
            3'd5: c = COLOR_RED;
            3'd6: c = COLOR_BLUE;
            3'd7: c = COLOR_BLACK;
        endcase
        return c;
    endfunction

    // One axis of the bouncing box; returns {dir_neg, pos}. Clamps at the wall
    // and reverses rather than overshooting.
    function automatic logic [13:0] box_axis_step(input logic [12:0] pos,
                                                  input logic        dir_neg,
                                                  input logic [12:0] lim,
                                                  input logic [12:0] step);
        logic [12:0] npos;
        logic        ndir;
        npos = pos;
        ndir = dir_neg;
        if (!dir_neg && (pos + step > lim)) begin
            npos = lim;
            ndir = 1'b1;
        end else if (dir_neg && (pos < step)) begin
            npos = '0;
            ndir = 1'b0;
        end else if (dir_neg) begin
            npos = pos - step;
        end else begin
            npos = pos + step;
        end
        return {ndir, npos};
    endfunction

endpackage

// File: rtl/lvds_pattern_gen_if.sv
// Pixel request/response bus between the LVDS transmitter and the pattern source.
interface lvds_pattern_gen_if;

    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] color;

    modport master (output x, output y, input color);
    modport slave (input x, input y, output color);

endinterface

// File: rtl/button_debounce.sv
// Push-button synchroniser and stable-level debouncer; emits a one-cycle pulse
// on each accepted rising edge.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned    CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q, last_q;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        // last_q holds the previous synchronised sample so any toggle restarts the count
        if (sync2_q != last_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            level_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            last_q  <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/lvds_pattern_gen.sv
// Test-pattern pixel source for the 960x1200 LVDS panel: maps (x, y) to RGB
// with a fixed two-cycle latency; patterns cycle on a debounced button press.
module lvds_pattern_gen
    import lvds_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned BOX_SIZE        = 64,
    parameter int unsigned BOX_STEP        = 4
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              button,
    lvds_pattern_gen_if.slave pix,
    output logic [1:0]        mode,
    output logic [7:0]        led
);

    localparam logic [12:0] BoxLimX  = 13'(HACTIVE - BOX_SIZE);
    localparam logic [12:0] BoxLimY  = 13'(VACTIVE - BOX_SIZE);
    localparam logic [12:0] BoxSize  = 13'(BOX_SIZE);
    localparam logic [12:0] BoxStep  = 13'(BOX_STEP);
    localparam logic [11:0] LastLine = 12'(VACTIVE - 1);

    logic        press;
    logic        tick;
    logic [12:0] x_ext, y_ext;

    // Control state
    mode_e       mode_q, mode_d;
    logic [11:0] y_q, y_d;
    logic [7:0]  led_q, led_d;
    logic [12:0] box_x_q, box_x_d, box_y_q, box_y_d;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;

    // Pipeline stage 1
    mode_e       mode1_q, mode1_d;
    logic [2:0]  bar_q, bar_d;
    logic        chk_q, chk_d;
    logic        in_box_q, in_box_d;
    logic [7:0]  grad_r_q, grad_r_d;
    logic [7:0]  grad_g_q, grad_g_d;

    // Pipeline stage 2
    logic [23:0] color_q, color_d;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_in (clk_in),
        .reset  (reset),
        .btn_i  (button),
        .press_o(press)
    );

    always_comb begin
        y_d     = pix.y;
        // y_q clears to 0 on reset, so the first frame after release cannot false-trigger
        tick    = (y_q == LastLine) && (pix.y == 12'd0);
        mode_d  = mode_q;
        led_d   = led_q;
        box_x_d = box_x_q;
        dir_x_d = dir_x_q;
        box_y_d = box_y_q;
        dir_y_d = dir_y_q;
        if (press) begin
            mode_d = mode_e'(mode_q + 2'd1);
        end
        if (tick) begin
            led_d              = led_q + 8'd1;
            {dir_x_d, box_x_d} = box_axis_step(box_x_q, dir_x_q, BoxLimX, BoxStep);
            {dir_y_d, box_y_d} = box_axis_step(box_y_q, dir_y_q, BoxLimY, BoxStep);
        end
    end

    always_comb begin
        x_ext = {1'b0, pix.x};
        y_ext = {1'b0, pix.y};
        bar_d = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x_ext >= 13'(k * BAR_WIDTH)) begin
                bar_d = 3'(k);
            end
        end
        chk_d    = pix.x[5] ^ pix.y[5];
        in_box_d = (x_ext >= box_x_q) && (x_ext < box_x_q + BoxSize) &&
                   (y_ext >= box_y_q) && (y_ext < box_y_q + BoxSize);
        grad_r_d = pix.x[9:2];
        grad_g_d = pix.y[10:3];
        mode1_d  = mode_q;
    end

    // Colour is chosen only from stage-1 fields, so each word uses exactly one mode.
    always_comb begin
        color_d = COLOR_BLACK;
        unique case (mode1_q)
            MODE_BARS:  color_d = bar_color(bar_q);
            MODE_GRAD:  color_d = {grad_r_q, grad_g_q, GRAD_BLUE};
            MODE_CHECK: color_d = chk_q ? COLOR_WHITE : COLOR_BLACK;
            MODE_BOX:   color_d = in_box_q ? BOX_FG : BOX_BG;
            default:    color_d = COLOR_BLACK;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            mode_q   <= MODE_BARS;
            y_q      <= '0;
            led_q    <= '0;
            box_x_q  <= '0;
            box_y_q  <= '0;
            dir_x_q  <= 1'b0;
            dir_y_q  <= 1'b0;
            mode1_q  <= MODE_BARS;
            bar_q    <= '0;
            chk_q    <= 1'b0;
            in_box_q <= 1'b0;
            grad_r_q <= '0;
            grad_g_q <= '0;
            color_q  <= '0;
        end else begin
            mode_q   <= mode_d;
            y_q      <= y_d;
            led_q    <= led_d;
            box_x_q  <= box_x_d;
            box_y_q  <= box_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            mode1_q  <= mode1_d;
            bar_q    <= bar_d;
            chk_q    <= chk_d;
            in_box_q <= in_box_d;
            grad_r_q <= grad_r_d;
            grad_g_q <= grad_g_d;
            color_q  <= color_d;
        end
    end

    assign pix.color = color_q;
    assign mode      = mode_q;
    assign led       = led_q;

endmodule
